// File: rtl/bf16_mul_out_stage.sv
// Output stage of the BF16 multiplier: a two-entry skid buffer with sticky flags and a saturating op counter.
// Define BF16_MUL_OUT_FTZ_EN to flush subnormal products to signed zero on capture.
module bf16_mul_out_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_p,
  input  logic [3:0]       in_flags,
  input  logic [5:0]       in_class,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_p,
  output logic [3:0]       out_flags,
  output logic [5:0]       out_class,
  output logic [3:0]       fflags,
  input  logic             fflags_clr,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state, state_nxt;
  logic             ready_q, valid_q;
  logic             accept, deliver;
  logic [25:0]      main_q, skid_q;
  logic [25:0]      cap;
  logic [15:0]      cap_p;
  logic [3:0]       cap_flags;
  logic [5:0]       cap_class;
  logic [3:0]       fflags_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign accept  = in_valid & ready_q;
  assign deliver = valid_q & out_ready;

  // Capture path: optional flush-to-zero of subnormal products
  always_comb begin
    cap_p     = in_p;
    cap_flags = in_flags;
    cap_class = in_class;
`ifdef BF16_MUL_OUT_FTZ_EN
    if (in_class[3]) begin
      cap_p     = {in_p[15], 15'b0};
      cap_class = 6'b000001;
      cap_flags = in_flags | 4'b0011;
    end
`endif
  end

  assign cap = {cap_p, cap_flags, cap_class};

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept) state_nxt = ONE;
      ONE: begin
        if (accept && !deliver)      state_nxt = FULL;
        else if (deliver && !accept) state_nxt = EMPTY;
      end
      FULL:    if (deliver) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Handshake outputs are registered copies of the next-state decode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != FULL);
      valid_q <= (state_nxt != EMPTY);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: if (accept) main_q <= cap;
        ONE: begin
          if (accept && deliver) main_q <= cap;
          else if (accept)       skid_q <= cap;
        end
        FULL:    if (deliver) main_q <= skid_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fflags_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) begin
        fflags_q <= (fflags_clr ? 4'b0 : fflags_q) | cap_flags;
        count_q  <= sat_inc(count_q);
      end else if (fflags_clr) begin
        fflags_q <= '0;
      end
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_p     = main_q[25:10];
  assign out_flags = main_q[9:6];
  assign out_class = main_q[5:0];
  assign fflags    = fflags_q;
  assign op_count  = count_q;

endmodule

// File: tb/tb_bf16_mul_out_stage.sv
// Self-checking bench for bf16_mul_out_stage: directed vectors, corner sequences and a random run against a queue model.
module tb_bf16_mul_out_stage;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, fflags_clr;
  logic [15:0] in_p, out_p;
  logic [3:0] in_flags, out_flags, fflags;
  logic [5:0] in_class, out_class;
  logic [CNT_W-1:0] op_count;

  bf16_mul_out_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_p(in_p), .in_flags(in_flags), .in_class(in_class),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .out_flags(out_flags), .out_class(out_class), .fflags(fflags),
    .fflags_clr(fflags_clr), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] p;
    logic [3:0]  f;
    logic [5:0]  c;
  } item_t;

  typedef struct {
    logic [15:0] p;  logic [3:0] f;  logic [5:0] c;
    logic [15:0] ep; logic [3:0] ef; logic [5:0] ec;
  } vec_t;

  int checks = 0;
  int failures = 0;
  item_t q[$];
  logic [3:0] m_fflags = '0;
  int m_count = 0;
  int delivered = 0;

  // Reference capture rule: subnormal results become signed zero when FTZ is built in
  function automatic item_t ref_capture(input logic [15:0] p, input logic [3:0] f, input logic [5:0] c);
    item_t it;
    it.p = p; it.f = f; it.c = c;
`ifdef BF16_MUL_OUT_FTZ_EN
    if (c[3]) begin
      it.p = p & 16'h8000;
      it.c = 6'b000001;
      it.f = f | 4'b0011;
    end
`endif
    return it;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_p", 32'(out_p), 32'(q[0].p));
      chk("out_flags", 32'(out_flags), 32'(q[0].f));
      chk("out_class", 32'(out_class), 32'(q[0].c));
    end
    chk("fflags", 32'(fflags), 32'(m_fflags));
    chk("op_count", 32'(op_count), 32'((m_count > CMAX) ? CMAX : m_count));
  endtask

  // One clock: model follows the handshakes seen before the edge, then outputs are checked at negedge
  task automatic cycle();
    bit acc, dlv;
    item_t it;
    acc = in_valid && (q.size() < 2);
    dlv = (q.size() > 0) && out_ready;
    it = ref_capture(in_p, in_flags, in_class);
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_fflags = '0;
      m_count = 0;
    end else begin
      if (dlv) begin
        void'(q.pop_front());
        delivered++;
      end
      if (acc) begin
        q.push_back(it);
        m_fflags = (fflags_clr ? 4'b0 : m_fflags) | it.f;
        m_count++;
      end else if (fflags_clr) begin
        m_fflags = '0;
      end
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic offer(input logic [15:0] p, input logic [3:0] f, input logic [5:0] c);
    in_valid = 1'b1; in_p = p; in_flags = f; in_class = c;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{16'h3F80, 4'b0000, 6'b000100, 16'h3F80, 4'b0000, 6'b000100};
    vecs[1] = '{16'h7F80, 4'b0100, 6'b000010, 16'h7F80, 4'b0100, 6'b000010};
    vecs[2] = '{16'h4000, 4'b0001, 6'b000110, 16'h4000, 4'b0001, 6'b000110};
`ifdef BF16_MUL_OUT_FTZ_EN
    vecs[3] = '{16'h8040, 4'b0001, 6'b001000, 16'h8000, 4'b0011, 6'b000001};
    vecs[4] = '{16'h0001, 4'b1000, 6'b001000, 16'h0000, 4'b1011, 6'b000001};
`else
    vecs[3] = '{16'h8040, 4'b0001, 6'b001000, 16'h8040, 4'b0001, 6'b001000};
    vecs[4] = '{16'h0001, 4'b1000, 6'b001000, 16'h0001, 4'b1000, 6'b001000};
`endif

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; fflags_clr = 1'b0;
    in_p = '0; in_flags = '0; in_class = '0;
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_p", 32'(out_p), 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    chk("rst_out_class", 32'(out_class), 32'd0);
    chk("rst_fflags", 32'(fflags), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    rst_n = 1'b1;

    // Single item, one-cycle latency
    offer(16'h3F80, 4'b0000, 6'b000100);
    cycle();
    in_valid = 1'b0;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_p", 32'(out_p), 32'h3F80);
    chk("single_count", 32'(op_count), 32'd1);
    chk("single_fflags", 32'(fflags), 32'd0);
    cycle();

    // Table vectors, including the FTZ-sensitive subnormal cases
    foreach (vecs[i]) begin
      offer(vecs[i].p, vecs[i].f, vecs[i].c);
      cycle();
      in_valid = 1'b0;
      chk("vec_p", 32'(out_p), 32'(vecs[i].ep));
      chk("vec_flags", 32'(out_flags), 32'(vecs[i].ef));
      chk("vec_class", 32'(out_class), 32'(vecs[i].ec));
      cycle();
    end

    // Backpressure: two accepted, third held, then ordered drain
    out_ready = 1'b0;
    delivered = 0;
    offer(16'h3F80, 4'b0000, 6'b000100); cycle();
    offer(16'h4000, 4'b0000, 6'b000100); cycle();
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    offer(16'h4040, 4'b0000, 6'b000100); cycle();
    chk("bp_held_ready", 32'(in_ready), 32'd0);
    chk("bp_head_stable", 32'(out_p), 32'h3F80);
    out_ready = 1'b1;
    cycle();
    chk("bp_second", 32'(out_p), 32'h4000);
    cycle();
    in_valid = 1'b0;
    chk("bp_third", 32'(out_p), 32'h4040);
    cycle();
    chk("bp_delivered", 32'(delivered), 32'd3);
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Sticky flags and clear-with-accept
    fflags_clr = 1'b1; cycle(); fflags_clr = 1'b0;
    offer(16'h3F80, 4'b0100, 6'b000100); cycle();
    offer(16'h3F80, 4'b0001, 6'b000100); cycle();
    in_valid = 1'b0;
    chk("fflags_or", 32'(fflags), 32'b0101);
    offer(16'h3F80, 4'b1000, 6'b000100); fflags_clr = 1'b1; cycle();
    in_valid = 1'b0; fflags_clr = 1'b0;
    chk("fflags_clr_acc", 32'(fflags), 32'b1000);
    cycle();

    // Counter saturation, then reset while FULL
    for (int i = 0; i < 20; i++) begin
      offer(16'(i), 4'b0000, 6'b000100);
      cycle();
    end
    in_valid = 1'b0;
    chk("count_sat", 32'(op_count), 32'd15);
    out_ready = 1'b0;
    offer(16'h1111, 4'b0000, 6'b000100); cycle();
    offer(16'h2222, 4'b0000, 6'b000100); cycle();
    chk("full_before_rst", 32'(in_ready), 32'd0);
    rst_n = 1'b0; cycle(); rst_n = 1'b1; in_valid = 1'b0;
    chk("rst_full_valid", 32'(out_valid), 32'd0);
    chk("rst_full_ready", 32'(in_ready), 32'd1);
    chk("rst_full_count", 32'(op_count), 32'd0);

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      in_p       = 16'($urandom);
      in_flags   = 4'($urandom);
      in_class   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(1 << $urandom_range(0, 5));
      fflags_clr = ($urandom_range(0, 9) == 0);
      rst_n      = ($urandom_range(0, 99) != 0);
      cycle();
    end
    rst_n = 1'b1; in_valid = 1'b0; fflags_clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
